// File: rtl/piso_tx_8bit.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out LSB first, one bit per clock, with gapless back-to-back words.
module piso_tx_8bit #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] sh_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             last_s;

  assign last_s = (state_r == SHIFT) && (cnt_r == LAST);

  // State, shift register and bit counter; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state_r <= IDLE;
      sh_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: load on acceptance, otherwise shift right filling the MSB with 0.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = SHIFT;
          sh_s    = din;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST) begin
          // Last bit on the wire: a pending word follows with no idle cycle.
          if (load) begin
            state_s = SHIFT;
            sh_s    = din;
            cnt_s   = {CW{1'b0}};
          end else begin
            state_s = IDLE;
            sh_s    = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          sh_s  = {1'b0, sh_r[WIDTH-1:1]};
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        sh_s    = {WIDTH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode straight from the registered state so all outputs move only after clock edges.
  always_comb begin
    din_ready = 1'b1;
    sout      = IDLE_LVL;
    sout_en   = 1'b0;
    done      = 1'b0;
    if (state_r == SHIFT) begin
      din_ready = last_s;
      sout      = sh_r[0];
      sout_en   = 1'b1;
      done      = last_s;
    end else begin
      din_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_tx_8bit.sv
// Bench for piso_tx_8bit: table-driven vectors, hand sequences for reset/loopback/
// WIDTH=4 corners, and random traffic against a bit-queue reference model.
module tb_piso_tx_8bit;

  logic       clk;
  logic       rs_n;
  logic       load8;
  logic [7:0] din8;
  logic       ready8, sout8, en8, done8;
  logic       load4;
  logic [3:0] din4;
  logic       ready4, sout4, en4, done4;
  logic [7:0] po;

  int total = 0;
  int bad   = 0;

  piso_tx_8bit #(.WIDTH(8), .IDLE_LVL(1'b0)) dut8 (
    .clk(clk), .rs_n(rs_n), .load(load8), .din(din8),
    .din_ready(ready8), .sout(sout8), .sout_en(en8), .done(done8)
  );

  piso_tx_8bit #(.WIDTH(4), .IDLE_LVL(1'b1)) dut4 (
    .clk(clk), .rs_n(rs_n), .load(load4), .din(din4),
    .din_ready(ready4), .sout(sout4), .sout_en(en4), .done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Negedge SIPO receiver: right shift, new bit enters at the MSB.
  always @(negedge clk) po <= {sout8, po[7:1]};

  // Reference model: queue of bits still to appear on the wire; head is the current bit.
  bit mq[$];

  typedef struct {
    logic       l;
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       dn;
    logic       r;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic l, input logic [7:0] d, input logic s,
                     input logic e, input logic dn, input logic r);
    vec_t v;
    v.l = l; v.d = d; v.s = s; v.e = e; v.dn = dn; v.r = r;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, advance the model at the rising edge, return at the falling edge.
  task automatic step(input logic l, input logic [7:0] d);
    bit rdy_pre;
    load8 = l;
    din8  = d;
    @(posedge clk);
    rdy_pre = (mq.size() <= 1);
    if (mq.size() > 0) void'(mq.pop_front());
    if (l && rdy_pre) for (int k = 0; k < 8; k++) mq.push_back(d[k]);
    @(negedge clk);
  endtask

  task automatic chk_model(input string nm);
    logic es, ee, ed, er;
    ee = (mq.size() > 0);
    es = ee ? mq[0] : 1'b0;
    ed = (mq.size() == 1);
    er = (mq.size() <= 1);
    chk({nm, ".sout"}, {7'd0, sout8}, {7'd0, es});
    chk({nm, ".sout_en"}, {7'd0, en8}, {7'd0, ee});
    chk({nm, ".done"}, {7'd0, done8}, {7'd0, ed});
    chk({nm, ".din_ready"}, {7'd0, ready8}, {7'd0, er});
  endtask

  initial begin
    logic [3:0] w4;
    rs_n  = 1'b1;
    load8 = 1'b0;
    din8  = 8'h00;
    load4 = 1'b0;
    din4  = 4'h0;

    // Single word 8'hA5: bits 1,0,1,0,0,1,0,1 then idle.
    add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back 8'h01 then 8'h80 with load held high.
    add(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 7; i++) add(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 10; i <= 15; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // 8'h00 frame with load+8'hFF asserted from bit 3 onward: ignored.
    add(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 7; i++) add(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state, checked before any clock edge has occurred.
    #1 rs_n = 1'b0;
    #2;
    chk("rst.sout", {7'd0, sout8}, 8'd0);
    chk("rst.sout_en", {7'd0, en8}, 8'd0);
    chk("rst.done", {7'd0, done8}, 8'd0);
    chk("rst.din_ready", {7'd0, ready8}, 8'd1);
    chk("rst.sout4", {7'd0, sout4}, 8'd1);
    @(negedge clk);
    rs_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].l, vt[i].d);
      chk($sformatf("vec%0d.sout", i), {7'd0, sout8}, {7'd0, vt[i].s});
      chk($sformatf("vec%0d.sout_en", i), {7'd0, en8}, {7'd0, vt[i].e});
      chk($sformatf("vec%0d.done", i), {7'd0, done8}, {7'd0, vt[i].dn});
      chk($sformatf("vec%0d.din_ready", i), {7'd0, ready8}, {7'd0, vt[i].r});
    end

    // Receiver loopback with 8'h3C.
    step(1'b1, 8'h3C);
    for (int i = 1; i < 8; i++) step(1'b0, 8'h00);
    #1 chk("loopback.po", po, 8'h3C);
    step(1'b0, 8'h00);

    // Asynchronous reset three bits into 8'hFF.
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("midrst.pre_sout", {7'd0, sout8}, 8'd1);
    #2 rs_n = 1'b0;
    #1;
    chk("midrst.sout", {7'd0, sout8}, 8'd0);
    chk("midrst.sout_en", {7'd0, en8}, 8'd0);
    chk("midrst.done", {7'd0, done8}, 8'd0);
    #1 rs_n = 1'b1;
    mq.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00);
      chk("postrst.sout_en", {7'd0, en8}, 8'd0);
      chk("postrst.sout", {7'd0, sout8}, 8'd0);
      chk("postrst.din_ready", {7'd0, ready8}, 8'd1);
    end

    // WIDTH=4, IDLE_LVL=1: send 4'b0110.
    w4 = 4'b0110;
    load4 = 1'b1;
    din4  = w4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      load4 = 1'b0;
      din4  = 4'hF;
      chk($sformatf("w4.bit%0d", k), {7'd0, sout4}, {7'd0, w4[k]});
      chk($sformatf("w4.en%0d", k), {7'd0, en4}, 8'd1);
      chk($sformatf("w4.done%0d", k), {7'd0, done4}, (k == 3) ? 8'd1 : 8'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("w4.idle_sout", {7'd0, sout4}, 8'd1);
    chk("w4.idle_en", {7'd0, en4}, 8'd0);
    chk("w4.idle_done", {7'd0, done4}, 8'd0);
    chk("w4.idle_ready", {7'd0, ready4}, 8'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 8'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
